mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake. It has two modes. Direct mode forwards a host-selected channel. Scan mode auto-sequences round-robin through the enabled channels, emitting DWELL+1 samples per channel before advancing. It sits between a bank of sampled data sources and a single downstream consumer (serialiser, logger, display driver).

Parameters:
N_CH, 8, number of input channels (2..256; need not be a power of two)
DATA_W, 8, bits per channel
DWELL_W, 8, width of the dwell count input
SEL_W, $clog2(N_CH), channel index width (derived, do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
data_in  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
ch_en  input  N_CH  per-channel enable mask (scan mode and direct mode)
mode  input  1  0 = direct, 1 = scan
sel  input  SEL_W  channel index in direct mode
dwell  input  DWELL_W  extra samples per channel in scan mode (samples per channel = dwell+1)
out_data  output  DATA_W  registered sample
out_ch  output  SEL_W  channel index of out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts when out_valid && out_ready
scan_wrap  output  1  one-cycle pulse: scan pointer wrapped to a lower index

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values:
  - out_data = 0, out_ch = 0, out_valid = 0, scan_wrap = 0.
  - Internal ptr = 0, cnt = 0, prev_mode = 0.
  - rst mid-transfer discards the held sample; no handshake is completed.
- Load condition: L = !out_valid || out_ready.
- When !L (stall), out_data, out_ch and out_valid hold, and ptr/cnt hold. Output must stay stable while valid and not ready.
- Latency: a sample is captured on the clk edge where L = 1 and appears on the outputs at that edge. data_in is sampled at the same edge (1-cycle register latency).
- Direct mode (mode = 0), on L:
  - If sel < N_CH and ch_en[sel]: out_data <= data_in[sel], out_ch <= sel, out_valid <= 1.
  - Otherwise out_valid <= 0; out_data and out_ch hold.
  - ptr and cnt are forced to 0 every cycle in direct mode (independent of L).
- Scan mode (mode = 1):
  - next_en(p) = first enabled index in circular order p+1, p+2, ..., wrapping past N_CH-1 to 0, and including p itself last.
  - cur = ch_en[ptr] ? ptr : next_en(ptr).
  - On L with |ch_en = 1:
    - out_data <= data_in[cur], out_ch <= cur, out_valid <= 1.
    - If cur != ptr, the count restarts: the effective cnt is 0.
    - If effective cnt == dwell: cnt <= 0 and ptr <= next_en(cur). scan_wrap pulses for one cycle if next_en(cur) <= cur (this includes the single-enabled-channel case).
    - Else: cnt <= effective cnt + 1 and ptr <= cur.
  - On L with ch_en all zero: out_valid <= 0; ptr and cnt hold.
  - Changes to dwell take effect on the next comparison. If cnt > new dwell, the comparison uses >= so the pointer advances immediately.
- Mode switch:
  - A change of mode seen at an edge (mode != prev_mode) resets ptr and cnt to 0 before evaluation. Scan therefore always starts at the first enabled channel at or after index 0.
  - The output register follows the normal L rule; a stalled sample is not overwritten.
- scan_wrap is 0 in direct mode and whenever no sample is loaded.
- The enable-mask search must be combinational priority logic over N_CH; it must not iterate over cycles.

Test Plan:
- Reset/direct: N_CH = 8, DATA_W = 8, data_in channel i = 0x10+i, ch_en = 0xFF, mode = 0, out_ready = 1, sel = 5 → one cycle after rst drops, out_data = 0x15, out_ch = 5, out_valid = 1. During rst, all outputs are 0.
- Direct disabled/out-of-range: N_CH = 6, sel = 7 → out_valid = 0. ch_en[3] = 0 and sel = 3 → out_valid = 0, out_data holds its previous value.
- Scan dwell: mode = 1, dwell = 1, ch_en = 0x0D (channels 0, 2, 3), out_ready = 1 → out_ch sequence 0,0,2,2,3,3,0,0. scan_wrap is high on the cycle the second ch3 sample loads, and nowhere else.
- Backpressure: scan, dwell = 0, ch_en = 0xFF, out_ready low for 4 cycles while out_ch = 2 → out_ch/out_data/out_valid are stable for all 4 cycles. After out_ready rises, the sequence continues 3,4,… with no channel skipped or repeated.
- Mask change mid-scan: scan, dwell = 3, after 2 samples of ch 1 clear ch_en[1] → the next sample is ch 2 with a fresh count of 4 samples. ch_en = 0 → out_valid drops to 0 on the next L, and ptr holds.
- Mode switch and reset mid-scan: scan running at ptr = 4 → mode = 0 then mode = 1 → scan restarts at ch 0. Assert rst while out_valid = 1 and out_ready = 0 → the next cycle has out_valid = 0, ptr = 0, and no scan_wrap.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// N-channel registered multiplexer with valid/ready output.
// Direct mode forwards a selected channel; scan mode walks the enabled channels round-robin.
module mux_nto1_scan #(
   parameter int N_CH    = 8,
   parameter int DATA_W  = 8,
   parameter int DWELL_W = 8,
   parameter int SEL_W   = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   input  logic [N_CH-1:0]          ch_en,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [DWELL_W-1:0]       dwell,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     scan_wrap
);

   localparam logic [SEL_W:0] NCH = (SEL_W+1)'(N_CH);

   logic [N_CH-1:0][DATA_W-1:0] ch_data;
   logic [SEL_W-1:0]            ptr, ptr_eff, cur, nxt;
   logic [DWELL_W-1:0]          cnt, cnt_base, cnt_eff;
   logic                        prev_mode, load, mode_chg, any_en, sel_ok, last;

   assign ch_data = data_in;

   // First enabled channel after p in circular order, p itself checked last.
   // Unrolled over N_CH, so it is pure priority logic.
   function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] p,
                                                input logic [N_CH-1:0]  en);
      logic [SEL_W-1:0] r;
      logic [SEL_W:0]   idx;
      logic             found;
      r     = p;
      found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = {1'b0, p} + (SEL_W+1)'(k);
         if (idx >= NCH) idx = idx - NCH;
         if (!found && en[idx[SEL_W-1:0]]) begin
            r     = idx[SEL_W-1:0];
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign load     = !out_valid || out_ready;
   assign mode_chg = mode != prev_mode;
   assign any_en   = |ch_en;
   assign ptr_eff  = mode_chg ? '0 : ptr;
   assign cnt_base = mode_chg ? '0 : cnt;
   assign cur      = ch_en[ptr_eff] ? ptr_eff : next_en(ptr_eff, ch_en);
   // Landing on a different channel than ptr restarts its dwell count.
   assign cnt_eff  = (cur != ptr_eff) ? '0 : cnt_base;
   assign last     = cnt_eff >= dwell;
   assign nxt      = next_en(cur, ch_en);
   assign sel_ok   = ({1'b0, sel} < NCH) && ch_en[sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         scan_wrap <= 1'b0;
         ptr       <= '0;
         cnt       <= '0;
         prev_mode <= 1'b0;
      end else begin
         prev_mode <= mode;
         scan_wrap <= 1'b0;
         if (!mode) begin
            ptr <= '0;
            cnt <= '0;
            if (load) begin
               if (sel_ok) begin
                  out_data  <= ch_data[sel];
                  out_ch    <= sel;
                  out_valid <= 1'b1;
               end else begin
                  out_valid <= 1'b0;
               end
            end
         end else begin
            ptr <= ptr_eff;
            cnt <= cnt_base;
            if (load) begin
               if (any_en) begin
                  out_data  <= ch_data[cur];
                  out_ch    <= cur;
                  out_valid <= 1'b1;
                  if (last) begin
                     cnt       <= '0;
                     ptr       <= nxt;
                     scan_wrap <= (nxt <= cur);
                  end else begin
                     cnt <= cnt_eff + 1'b1;
                     ptr <= cur;
                  end
               end else begin
                  out_valid <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench: an 8-channel instance for reset/direct/scan behaviour and
// a 6-channel instance for out-of-range and disabled direct selects.
module tb_mux_nto1_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 8-channel DUT
   logic        rst;
   logic [63:0] data8;
   logic [7:0]  en8;
   logic        mode8;
   logic [2:0]  sel8;
   logic [7:0]  dwell8;
   logic [7:0]  od8;
   logic [2:0]  oc8;
   logic        ov8, rdy8, wrap8;

   // 6-channel DUT
   logic [47:0] data6;
   logic [5:0]  en6;
   logic [2:0]  sel6;
   logic [7:0]  od6;
   logic [2:0]  oc6;
   logic        ov6, wrap6;

   mux_nto1_scan #(.N_CH(8), .DATA_W(8), .DWELL_W(8)) dut8 (
      .clk(clk), .rst(rst), .data_in(data8), .ch_en(en8), .mode(mode8),
      .sel(sel8), .dwell(dwell8), .out_data(od8), .out_ch(oc8),
      .out_valid(ov8), .out_ready(rdy8), .scan_wrap(wrap8));

   mux_nto1_scan #(.N_CH(6), .DATA_W(8), .DWELL_W(8)) dut6 (
      .clk(clk), .rst(rst), .data_in(data6), .ch_en(en6), .mode(1'b0),
      .sel(sel6), .dwell(8'd0), .out_data(od6), .out_ch(oc6),
      .out_valid(ov6), .out_ready(1'b1), .scan_wrap(wrap6));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input int ch, input bit v, input bit w);
      chk({tag, " valid"}, 32'(ov8), 32'(v));
      chk({tag, " ch"}, 32'(oc8), 32'(ch));
      chk({tag, " data"}, 32'(od8), 32'(8'h10 + ch));
      chk({tag, " wrap"}, 32'(wrap8), 32'(w));
   endtask

   int seq_a[8] = '{0, 0, 2, 2, 3, 3, 0, 0};
   int seq_m[9] = '{0, 0, 0, 0, 1, 1, 2, 2, 2};

   initial begin
      for (int i = 0; i < 8; i++) data8[i*8 +: 8] = 8'(8'h10 + i);
      for (int i = 0; i < 6; i++) data6[i*8 +: 8] = 8'(8'h20 + i);
      rst = 1'b1; en8 = 8'hFF; mode8 = 1'b0; sel8 = 3'd5; dwell8 = 8'd0; rdy8 = 1'b1;
      en6 = 6'h3F; sel6 = 3'd1;

      // reset state
      tick();
      tick();
      chk("rst data", 32'(od8), 0);
      chk("rst ch", 32'(oc8), 0);
      chk("rst valid", 32'(ov8), 0);
      chk("rst wrap", 32'(wrap8), 0);
      chk("rst ptr", 32'(dut8.ptr), 0);

      // direct mode
      rst = 1'b0;
      tick();
      chk8("dir sel5", 5, 1'b1, 1'b0);
      chk("d6 sel1 valid", 32'(ov6), 1);
      chk("d6 sel1 data", 32'(od6), 32'h21);
      sel6 = 3'd7;
      tick();
      chk("d6 oor valid", 32'(ov6), 0);
      chk("d6 oor data hold", 32'(od6), 32'h21);
      sel6 = 3'd2;
      tick();
      chk("d6 sel2 data", 32'(od6), 32'h22);
      chk("d6 sel2 valid", 32'(ov6), 1);
      en6 = 6'h37; sel6 = 3'd3;
      tick();
      chk("d6 dis valid", 32'(ov6), 0);
      chk("d6 dis data hold", 32'(od6), 32'h22);
      chk("d6 dis ch hold", 32'(oc6), 2);

      // scan with dwell=1 over channels 0,2,3
      mode8 = 1'b1; dwell8 = 8'd1; en8 = 8'h0D;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk8($sformatf("scanA[%0d]", i), seq_a[i], 1'b1, i == 5);
      end

      // restart scan, dwell=0, backpressure on ch2
      mode8 = 1'b0; en8 = 8'hFF; dwell8 = 8'd0;
      tick();
      chk8("dir between", 5, 1'b1, 1'b0);
      mode8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk8($sformatf("scanB[%0d]", i), i, 1'b1, 1'b0);
      end
      rdy8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk8($sformatf("stall[%0d]", i), 2, 1'b1, 1'b0);
      end
      rdy8 = 1'b1;
      for (int i = 3; i < 9; i++) begin
         tick();
         chk8($sformatf("scanC[%0d]", i), i % 8, 1'b1, i == 7);
      end

      // mask change mid-scan, dwell=3
      mode8 = 1'b0;
      tick();
      mode8 = 1'b1; dwell8 = 8'd3;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk8($sformatf("scanM[%0d]", i), seq_m[i], 1'b1, 1'b0);
         if (i == 5) en8 = 8'hFD;
      end
      tick();
      chk8("scanM tail", 2, 1'b1, 1'b0);
      tick();
      chk8("scanM ch3", 3, 1'b1, 1'b0);
      en8 = 8'h00;
      tick();
      chk("none valid", 32'(ov8), 0);
      chk("none ptr hold", 32'(dut8.ptr), 3);
      chk("none ch hold", 32'(oc8), 3);
      tick();
      chk("none2 ptr hold", 32'(dut8.ptr), 3);
      chk("none2 wrap", 32'(wrap8), 0);

      // mode switch at ptr=4 restarts at ch0
      en8 = 8'hFF; dwell8 = 8'd0;
      tick();
      chk8("resume ch3", 3, 1'b1, 1'b0);
      chk("resume ptr", 32'(dut8.ptr), 4);
      mode8 = 1'b0;
      tick();
      chk8("switch dir", 5, 1'b1, 1'b0);
      mode8 = 1'b1;
      tick();
      chk8("restart ch0", 0, 1'b1, 1'b0);
      tick();
      chk8("restart ch1", 1, 1'b1, 1'b0);

      // reset while stalled with a valid sample
      rdy8 = 1'b0;
      tick();
      chk8("pre-rst hold", 1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk("midrst valid", 32'(ov8), 0);
      chk("midrst ch", 32'(oc8), 0);
      chk("midrst data", 32'(od8), 0);
      chk("midrst wrap", 32'(wrap8), 0);
      chk("midrst ptr", 32'(dut8.ptr), 0);
      rst = 1'b0; rdy8 = 1'b1;
      tick();
      chk8("post-rst ch0", 0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
